dot_product_job_scheduler: RTL and testbench
============================================

# dot_product_job_scheduler

Round-robin scheduler that shares one 8-lane vector dot-product engine between `NUM_REQ` requesters. It grants one job at a time, streams the job's 8×8-bit chunks into the engine as one contiguous `compute` burst, waits for the engine's `out_valid`, and returns the 32-bit result tagged with the requester ID. It sits between the requester-side stream interfaces and the engine, and is the only driver of the engine's `compute`, `t_data` and `weights` inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8; `ID_W = $clog2(NUM_REQ)` is derived and not overridable.
- `LEN_W`, 8: width of job length in chunks.
- `TIMEOUT`, 64: maximum WAIT cycles before a job is failed (used only with the watchdog macro).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: job request per requester, level.
- `req_len` in NUM_REQ×LEN_W: job length in chunks, sampled at grant.
- `req_ack` out NUM_REQ: one-cycle grant pulse, one-hot.
- `dat_vld` in NUM_REQ: chunk valid per requester.
- `dat_t` in NUM_REQ×8×8: data chunk per requester.
- `dat_w` in NUM_REQ×8×8: weight chunk per requester.
- `dat_rdy` out NUM_REQ: chunk accepted this cycle when high together with `dat_vld`.
- `eng_compute` out 1: engine compute strobe, registered.
- `eng_t_data`, `eng_weights` out 8×8 each: engine operands, registered.
- `eng_out_valid` in 1: engine result strobe.
- `eng_dot_product` in 32: engine result.
- `res_valid` out 1: result valid, held until accepted.
- `res_ready` in 1: result accept.
- `res_data` out 32: result value.
- `res_id` out ID_W: requester index.
- `res_err` out 1: job failed (underrun, zero length, or timeout).
- `busy` out 1: high whenever state ≠ IDLE.
- `jobs_done` out 16: count of `res_valid & res_ready` handshakes, wraps at 0xFFFF→0.

## Operation
- States: IDLE, FEED, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0. The round-robin pointer resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.
- IDLE: if any `req_valid` is high, grant the first requester searching from pointer+1 with wrap. Then:
  - latch `gnt`, `req_len[gnt]` into `remaining`, and set the pointer to `gnt`;
  - pulse `req_ack[gnt]` on the next cycle;
  - go to FEED, or to RESP with `res_err=1`, `res_data=0` if `req_len==0`. A zero-length job does not touch the engine.
- FEED: `dat_rdy[gnt]=1` combinationally; all other `dat_rdy` bits are 0.
  - Each cycle with `dat_vld[gnt]=1`, register `dat_t[gnt]`/`dat_w[gnt]` into the engine operands, set `eng_compute=1` next cycle, and decrement `remaining`.
  - Accepting the last chunk (`remaining==1`) moves to WAIT.
  - Underrun: `dat_vld[gnt]=0` in FEED sets a sticky error flag and moves to WAIT. This ends the engine burst early.
- WAIT: `eng_compute=0`, which provides the mandatory gap.
  - On `eng_out_valid`, capture `eng_dot_product` into `res_data` (forced to 0 if the error flag is set), set `res_err` to the error flag, set `res_id=gnt`, and go to RESP.
  - `eng_out_valid` outside WAIT is ignored.
- RESP: `res_valid=1`, with the result fields stable. On `res_ready`, go to IDLE, clear `res_valid` and the error flag, and increment `jobs_done`.
- Arithmetic: `remaining` is LEN_W bits unsigned; a maximum-length job is 2^LEN_W−1 chunks. The result is passed through unmodified.
- Reset mid-job: outputs and state return immediately to reset values. Any in-flight engine result after reset is ignored.

## Timing
- `req_valid` sampled at cycle 0 in IDLE → `req_ack` and first `dat_rdy` at cycle 1.
- A chunk accepted at cycle c appears as `eng_compute=1` with its operands at cycle c+1.
- A job of L chunks with no underrun gives exactly L consecutive `eng_compute` high cycles, followed by at least one low cycle.
- `eng_out_valid` at cycle w → `res_valid` at cycle w+1.
- Minimum time from RESP handshake to the next grant is 1 cycle (via IDLE). There is no combinational path from `req_valid` to `req_ack`.

## Configuration
- `DOT_SCHED_WATCHDOG_EN` defined:
  - a WAIT cycle counter runs, reset on WAIT entry;
  - if it reaches `TIMEOUT-1` without `eng_out_valid`, go to RESP with `res_err=1` and `res_data=0`.
- Not defined: no counter is present, and WAIT holds until `eng_out_valid` indefinitely. `TIMEOUT` is then unused.

## Test plan
- Single job: requester 0, `req_len=3`, `dat_vld` held high with chunks all-1s × all-2s → `eng_compute` high for exactly 3 cycles starting the cycle after `req_ack`; engine returns 48 → `res_data=48`, `res_id=0`, `res_err=0`, `jobs_done=1`.
- Round-robin: both requesters' `req_valid` held high for 4 jobs → grant order 0,1,0,1, with ≥1 `eng_compute` low cycle between bursts.
- Underrun: `req_len=4`, `dat_vld` dropped after 2 chunks → 2 compute cycles, `res_err=1`, `res_data=0`.
- Zero length: `req_len=0` → `req_ack` pulse, `eng_compute` never asserted, `res_valid` with `res_err=1`.
- Backpressure and reset: `res_ready` held low for 5 cycles → `res_valid`/`res_data` stable; then assert `rst_n=0` mid-FEED → all outputs 0 asynchronously, and the next grant goes to requester 0.
- Watchdog (macro defined, `TIMEOUT=8`): engine never returns `out_valid` → `res_err=1` after 8 WAIT cycles. With the macro undefined, the bench checks WAIT persists for 100 cycles.

Source files
------------

// File: rtl/dot_product_job_scheduler.sv
// dot_product_job_scheduler
//
// Round-robin scheduler sharing one 8-lane (8x8-bit) dot-product engine
// between NUM_REQ requesters. One job at a time is granted; its chunks are
// streamed into the engine as a single contiguous compute burst. The
// scheduler then waits for the engine result and returns it tagged with the
// requester index.
//
// Optional feature macro: DOT_SCHED_WATCHDOG_EN
//   defined   -> a WAIT-cycle counter fails the job after TIMEOUT WAIT cycles
//   undefined -> WAIT holds until eng_out_valid (TIMEOUT unused)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_len   per-requester job request (level) and length in chunks
//   req_ack             registered one-hot grant pulse
//   dat_vld/dat_t/dat_w per-requester chunk stream (data and weights)
//   dat_rdy             chunk accept, only the granted requester in FEED
//   eng_compute         registered engine strobe with eng_t_data/eng_weights
//   eng_out_valid       engine result strobe, eng_dot_product result
//   res_valid/res_ready result handshake; res_data/res_id/res_err payload
//   busy                scheduler not idle
//   jobs_done           count of completed result handshakes (wraps)
module dot_product_job_scheduler #(
  parameter  int NUM_REQ = 2,
  parameter  int LEN_W   = 8,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]               req_ack,
  input  logic [NUM_REQ-1:0]               dat_vld,
  input  logic [NUM_REQ-1:0][63:0]         dat_t,
  input  logic [NUM_REQ-1:0][63:0]         dat_w,
  output logic [NUM_REQ-1:0]               dat_rdy,
  output logic                             eng_compute,
  output logic [63:0]                      eng_t_data,
  output logic [63:0]                      eng_weights,
  input  logic                             eng_out_valid,
  input  logic [31:0]                      eng_dot_product,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [31:0]                      res_data,
  output logic [ID_W-1:0]                  res_id,
  output logic                             res_err,
  output logic                             busy,
  output logic [15:0]                      jobs_done
);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt;
  logic [LEN_W-1:0]  remaining;
  logic              err_flag;

`ifdef DOT_SCHED_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0]   wd_cnt;
`endif

  // Round-robin search starting just after the last grant, with wrap.
  logic              arb_hit;
  logic [ID_W-1:0]   arb_gnt;
  logic [ID_W-1:0]   cand;

  always_comb begin
    arb_hit = 1'b0;
    arb_gnt = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_gnt = cand;
      end
    end
  end

  always_comb begin
    dat_rdy = '0;
    if (state == FEED) dat_rdy[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Control and registered outputs; everything returns to zero on reset so
  // an in-flight job leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= ID_W'(NUM_REQ - 1);
      gnt         <= '0;
      remaining   <= '0;
      err_flag    <= 1'b0;
      req_ack     <= '0;
      eng_compute <= 1'b0;
      eng_t_data  <= '0;
      eng_weights <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_id      <= '0;
      res_err     <= 1'b0;
      jobs_done   <= '0;
`ifdef DOT_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      req_ack     <= '0;
      eng_compute <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_hit) begin
            gnt              <= arb_gnt;
            ptr              <= arb_gnt;
            remaining        <= req_len[arb_gnt];
            req_ack[arb_gnt] <= 1'b1;
            if (req_len[arb_gnt] == '0) begin
              // Zero-length job fails immediately without touching the engine.
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
              res_id    <= arb_gnt;
              state     <= RESP;
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
`ifdef DOT_SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          if (dat_vld[gnt]) begin
            eng_compute <= 1'b1;
            eng_t_data  <= dat_t[gnt];
            eng_weights <= dat_w[gnt];
            remaining   <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= WAIT;
          end else begin
            // Underrun: the burst must stay contiguous, so cut it short.
            err_flag <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (eng_out_valid) begin
            res_valid <= 1'b1;
            res_data  <= err_flag ? 32'd0 : eng_dot_product;
            res_err   <= err_flag;
            res_id    <= gnt;
            state     <= RESP;
          end
`ifdef DOT_SCHED_WATCHDOG_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_err   <= 1'b1;
            res_id    <= gnt;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            err_flag  <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_job_scheduler.sv
// Self-checking bench for dot_product_job_scheduler: directed scenarios plus
// randomized jobs, checked against a transaction-level model (round-robin
// pointer, expected chunk stream, expected result and completion count).
module tb_dot_product_job_scheduler;

  localparam int NR  = 3;
  localparam int LW  = 8;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0][LW-1:0]    req_len;
  logic [NR-1:0]            req_ack;
  logic [NR-1:0]            dat_vld;
  logic [NR-1:0][63:0]      dat_t;
  logic [NR-1:0][63:0]      dat_w;
  logic [NR-1:0]            dat_rdy;
  logic                     eng_compute;
  logic [63:0]              eng_t_data;
  logic [63:0]              eng_weights;
  logic                     eng_out_valid;
  logic [31:0]              eng_dot_product;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [IDW-1:0]           res_id;
  logic                     res_err;
  logic                     busy;
  logic [15:0]              jobs_done;

  int total = 0;
  int bad   = 0;
  int model_ptr;
  int jobs_model;
  int lens[NR];

  dot_product_job_scheduler #(.NUM_REQ(NR), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_len(req_len), .req_ack(req_ack),
    .dat_vld(dat_vld), .dat_t(dat_t), .dat_w(dat_w), .dat_rdy(dat_rdy),
    .eng_compute(eng_compute), .eng_t_data(eng_t_data), .eng_weights(eng_weights),
    .eng_out_valid(eng_out_valid), .eng_dot_product(eng_dot_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err), .busy(busy), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requester after the last grant, with wrap.
  function automatic int model_grant(input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++) begin
      if (m[(model_ptr + i) % NR]) return (model_ptr + i) % NR;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_dat_rdy"}, dat_rdy, 0);
    chk({tag, "_eng_compute"}, eng_compute, 0);
    chk({tag, "_eng_t_data"}, eng_t_data, 0);
    chk({tag, "_eng_weights"}, eng_weights, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  // One complete job from IDLE back to IDLE. drop_after<0 means no underrun;
  // lat is the number of extra WAIT cycles before the engine answers.
  task automatic do_job(input logic [NR-1:0] mask, input int drop_after,
                        input logic [31:0] eng_val, input int hold,
                        input int lat, input bit fixed);
    int g;
    int len;
    int k;
    bit err;
    bit drop;
    logic [NR-1:0] oh;
    logic [63:0] t;
    logic [63:0] w;
    logic [31:0] exp_data;
    g = model_grant(mask);
    req_valid = mask;
    for (int i = 0; i < NR; i++) req_len[i] = LW'(lens[i]);
    step();
    model_ptr = g;
    len = lens[g];
    oh = '0;
    oh[g] = 1'b1;
    chk("req_ack", req_ack, oh);
    chk("busy", busy, 1);
    if (len == 0) begin
      err = 1'b1;
      chk("zl_compute", eng_compute, 0);
      chk("zl_res_valid", res_valid, 1);
    end else begin
      err = 1'b0;
      k = 0;
      while (1) begin
        chk("dat_rdy", dat_rdy, oh);
        t = fixed ? {8{8'h01}} : {$urandom, $urandom};
        w = fixed ? {8{8'h02}} : {$urandom, $urandom};
        for (int i = 0; i < NR; i++) begin
          dat_vld[i] = $urandom_range(0, 1);
          dat_t[i]   = {$urandom, $urandom};
          dat_w[i]   = {$urandom, $urandom};
        end
        drop = (drop_after >= 0) && (k == drop_after);
        dat_vld[g] = !drop;
        dat_t[g]   = t;
        dat_w[g]   = w;
        eng_out_valid   = 1'($urandom_range(0, 1));
        eng_dot_product = $urandom;
        step();
        eng_out_valid = 1'b0;
        if (drop) begin
          err = 1'b1;
          chk("underrun_compute", eng_compute, 0);
          break;
        end
        chk("compute", eng_compute, 1);
        chk("t_data", eng_t_data, t);
        chk("weights", eng_weights, w);
        k++;
        if (k == len) break;
      end
      dat_vld = '0;
      for (int i = 0; i < lat; i++) begin
        step();
        chk("wait_compute", eng_compute, 0);
        chk("wait_res_valid", res_valid, 0);
        chk("wait_dat_rdy", dat_rdy, 0);
        chk("wait_busy", busy, 1);
      end
      eng_out_valid   = 1'b1;
      eng_dot_product = eng_val;
      step();
      eng_out_valid = 1'b0;
      chk("gap_compute", eng_compute, 0);
      chk("res_valid", res_valid, 1);
    end
    exp_data = err ? 32'd0 : eng_val;
    chk("res_data", res_data, exp_data);
    chk("res_err", res_err, err);
    chk("res_id", res_id, g);
    for (int i = 0; i < hold; i++) begin
      res_ready       = 1'b0;
      eng_out_valid   = 1'($urandom_range(0, 1));
      eng_dot_product = $urandom;
      step();
      eng_out_valid = 1'b0;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp_data);
      chk("hold_res_id", res_id, g);
      chk("hold_compute", eng_compute, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    jobs_model++;
    chk("done_res_valid", res_valid, 0);
    chk("jobs_done", jobs_done, jobs_model);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    int g;
    logic [NR-1:0] m;
    rst_n           = 1'b0;
    req_valid       = '0;
    req_len         = '0;
    dat_vld         = '0;
    dat_t           = '0;
    dat_w           = '0;
    eng_out_valid   = 1'b0;
    eng_dot_product = '0;
    res_ready       = 1'b0;
    model_ptr       = NR - 1;
    jobs_model      = 0;
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single job: all-1s x all-2s, three chunks, engine answers 48.
    lens = '{3, 0, 0};
    do_job(3'b001, -1, 32'd48, 1, 0, 1'b1);

    // Round-robin with two requesters held.
    lens = '{2, 3, 0};
    for (int j = 0; j < 4; j++) do_job(3'b011, -1, $urandom, 1, 0, 1'b0);

    // Underrun after two chunks of four.
    lens = '{4, 0, 0};
    do_job(3'b001, 2, $urandom, 0, 1, 1'b0);

    // Zero-length job.
    lens = '{0, 0, 0};
    do_job(3'b010, -1, $urandom, 2, 0, 1'b0);

    // Result backpressure for five cycles.
    lens = '{0, 0, 3};
    do_job(3'b100, -1, $urandom, 5, 2, 1'b0);

    // Maximum-length job.
    lens = '{255, 0, 0};
    do_job(3'b001, -1, $urandom, 0, 0, 1'b0);

`ifdef DOT_SCHED_WATCHDOG_EN
    // Engine never answers: job fails after TO WAIT cycles.
    lens = '{0, 1, 0};
    req_len[1] = LW'(1);
    g = model_grant(3'b010);
    req_valid = 3'b010;
    step();
    model_ptr = g;
    chk("wd_req_ack", req_ack, 3'b010);
    dat_vld[1] = 1'b1;
    step();
    dat_vld = '0;
    chk("wd_compute", eng_compute, 1);
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("wd_wait_res_valid", res_valid, 0);
    end
    step();
    chk("wd_res_valid", res_valid, 1);
    chk("wd_res_err", res_err, 1);
    chk("wd_res_data", res_data, 0);
    chk("wd_res_id", res_id, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    jobs_model++;
    chk("wd_jobs_done", jobs_done, jobs_model);
`else
    // Without the watchdog, WAIT persists for 100 cycles.
    lens = '{0, 1, 0};
    do_job(3'b010, -1, $urandom, 0, 100, 1'b0);
`endif

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) lens[i] = $urandom_range(0, 6);
      do_job(m, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a FEED burst.
    lens = '{5, 5, 0};
    req_len[0] = LW'(5);
    req_len[1] = LW'(5);
    g = model_grant(3'b011);
    req_valid = 3'b011;
    step();
    m = '0;
    m[g] = 1'b1;
    chk("rst_req_ack", req_ack, m);
    dat_vld[g] = 1'b1;
    dat_t[g]   = {$urandom, $urandom};
    dat_w[g]   = {$urandom, $urandom};
    step();
    step();
    chk("rst_pre_compute", eng_compute, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    chk_all_zero("rst_hold");
    rst_n      = 1'b1;
    model_ptr  = NR - 1;
    jobs_model = 0;
    req_valid  = '0;
    dat_vld    = '0;
    eng_out_valid   = 1'b1;
    eng_dot_product = $urandom;
    step();
    eng_out_valid = 1'b0;
    chk("rst_stale_res_valid", res_valid, 0);
    chk("rst_stale_busy", busy, 0);
    do_job(3'b011, -1, $urandom, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
